rx_ctrl: RTL and testbench

RX_CTRL -- requirements
Module: rx_ctrl

---
 rtl/rx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rx_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_ctrl
// Description : Decodes UART command bytes and turns them into vector-memory
//               loads (A/B) and one-hot operation commands with handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_ctrl #(
    parameter int N_ELEMENTS   = 1024,
    parameter int ADDR_W       = 10,
    parameter int BYTE_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              cmd_ack,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cmd_valid,
    output logic [5:0]        enables,
    output logic [1:0]        vec_loaded,
    output logic              rx_error
);

    localparam int                  C_CNT_W    = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0]   C_LAST_IDX = ADDR_W'(N_ELEMENTS - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(BYTE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_LOAD_B = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t              r_state_q,      w_state_d;
    logic [ADDR_W-1:0]   r_idx_q,        w_idx_d;
    logic [C_CNT_W-1:0]  r_idle_q,       w_idle_d;
    logic                r_wr_en_a_q,    w_wr_en_a_d;
    logic                r_wr_en_b_q,    w_wr_en_b_d;
    logic [ADDR_W-1:0]   r_wr_addr_q,    w_wr_addr_d;
    logic [7:0]          r_wr_data_q,    w_wr_data_d;
    logic                r_cmd_valid_q,  w_cmd_valid_d;
    logic [5:0]          r_enables_q,    w_enables_d;
    logic [1:0]          r_vec_loaded_q, w_vec_loaded_d;
    logic                r_rx_error_q,   w_rx_error_d;
    logic [2:0]          w_op;

    // Opcodes 0x03..0x08 map to enable bits 0..5 (3-bit wrap makes 0x08 -> 5)
    assign w_op = rx_data[2:0] - 3'd3;

    always_comb begin
        w_state_d      = r_state_q;
        w_idx_d        = r_idx_q;
        w_idle_d       = r_idle_q;
        w_wr_en_a_d    = 1'b0;
        w_wr_en_b_d    = 1'b0;
        w_wr_addr_d    = r_wr_addr_q;
        w_wr_data_d    = r_wr_data_q;
        w_cmd_valid_d  = r_cmd_valid_q;
        w_enables_d    = r_enables_q;
        w_vec_loaded_d = r_vec_loaded_q;
        w_rx_error_d   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    case (rx_data)
                        8'h01: begin
                            w_state_d         = S_LOAD_A;
                            w_vec_loaded_d[0] = 1'b0;
                            w_idx_d           = '0;
                            w_idle_d          = '0;
                        end
                        8'h02: begin
                            w_state_d         = S_LOAD_B;
                            w_vec_loaded_d[1] = 1'b0;
                            w_idx_d           = '0;
                            w_idle_d          = '0;
                        end
                        8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
                            if (r_vec_loaded_q == 2'b11) begin
                                w_state_d     = S_ISSUE;
                                w_cmd_valid_d = 1'b1;
                                w_enables_d   = 6'b000001 << w_op;
                            end else begin
                                w_rx_error_d  = 1'b1;
                            end
                        end
                        default: w_rx_error_d = 1'b1;
                    endcase
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                if (rx_ready) begin
                    w_wr_en_a_d = (r_state_q == S_LOAD_A);
                    w_wr_en_b_d = (r_state_q == S_LOAD_B);
                    w_wr_addr_d = r_idx_q;
                    w_wr_data_d = rx_data;
                    w_idx_d     = r_idx_q + 1'b1;
                    w_idle_d    = '0;
                    if (r_idx_q == C_LAST_IDX) begin
                        if (r_state_q == S_LOAD_A) begin
                            w_vec_loaded_d[0] = 1'b1;
                        end else begin
                            w_vec_loaded_d[1] = 1'b1;
                        end
                        w_state_d = S_IDLE;
                    end
                end else if (r_idle_q == C_CNT_LAST) begin
                    // A byte arriving on the expiry cycle wins over the timeout
                    w_rx_error_d = 1'b1;
                    w_state_d    = S_IDLE;
                end else begin
                    w_idle_d = r_idle_q + 1'b1;
                end
            end

            S_ISSUE: begin
                if (rx_ready) begin
                    w_rx_error_d = 1'b1;
                end
                if (cmd_ack) begin
                    w_cmd_valid_d = 1'b0;
                    w_enables_d   = '0;
                    w_state_d     = S_IDLE;
                end
            end

            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_idx_q        <= '0;
            r_idle_q       <= '0;
            r_wr_en_a_q    <= 1'b0;
            r_wr_en_b_q    <= 1'b0;
            r_wr_addr_q    <= '0;
            r_wr_data_q    <= '0;
            r_cmd_valid_q  <= 1'b0;
            r_enables_q    <= '0;
            r_vec_loaded_q <= '0;
            r_rx_error_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_idx_q        <= w_idx_d;
            r_idle_q       <= w_idle_d;
            r_wr_en_a_q    <= w_wr_en_a_d;
            r_wr_en_b_q    <= w_wr_en_b_d;
            r_wr_addr_q    <= w_wr_addr_d;
            r_wr_data_q    <= w_wr_data_d;
            r_cmd_valid_q  <= w_cmd_valid_d;
            r_enables_q    <= w_enables_d;
            r_vec_loaded_q <= w_vec_loaded_d;
            r_rx_error_q   <= w_rx_error_d;
        end
    end

    assign wr_en_a    = r_wr_en_a_q;
    assign wr_en_b    = r_wr_en_b_q;
    assign wr_addr    = r_wr_addr_q;
    assign wr_data    = r_wr_data_q;
    assign cmd_valid  = r_cmd_valid_q;
    assign enables    = r_enables_q;
    assign vec_loaded = r_vec_loaded_q;
    assign rx_error   = r_rx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_ctrl
// Description : Directed self-checking bench for rx_ctrl with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rx_ctrl;

    localparam int N_ELEMENTS   = 16;
    localparam int ADDR_W       = 4;
    localparam int BYTE_TIMEOUT = 50;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              cmd_ack;
    logic              wr_en_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              cmd_valid;
    logic [5:0]        enables;
    logic [1:0]        vec_loaded;
    logic              rx_error;

    typedef struct packed {
        logic              is_b;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              last;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    rx_ctrl #(
        .N_ELEMENTS   (N_ELEMENTS),
        .ADDR_W       (ADDR_W),
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .cmd_ack    (cmd_ack),
        .wr_en_a    (wr_en_a),
        .wr_en_b    (wr_en_b),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .enables    (enables),
        .vec_loaded (vec_loaded),
        .rx_error   (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for a single cycle; returns at the negedge after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic load_byte(input logic is_b, input int idx, input logic [7:0] b);
        wr_t e;
        e.is_b = is_b;
        e.addr = ADDR_W'(idx);
        e.data = b;
        e.last = (idx == N_ELEMENTS - 1);
        exp_q.push_back(e);
        send_byte(b);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'({wr_en_a, wr_en_b}), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_cmd"}, 32'({cmd_valid, enables}), 32'd0);
        chk({tag, "_vec_loaded"}, 32'(vec_loaded), 32'd0);
        chk({tag, "_rx_error"}, 32'(rx_error), 32'd0);
    endtask

    // Write-port monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (wr_en_a || wr_en_b) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'({wr_en_a, wr_en_b}), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_sel", 32'({wr_en_a, wr_en_b}), e.is_b ? 32'd1 : 32'd2);
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("vl_on_strobe", 32'(vec_loaded[e.is_b]), 32'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        cmd_ack  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Operation before any load is refused
        send_byte(8'h08);
        chk("early_op_err", 32'(rx_error), 32'd1);
        chk("early_op_cmd", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        chk("early_op_err_pulse", 32'(rx_error), 32'd0);

        // Load A with 0,1,2,...
        send_byte(8'h01);
        for (int i = 0; i < N_ELEMENTS; i++) load_byte(1'b0, i, 8'(i));
        chk("vl_after_a", 32'(vec_loaded), 32'd1);

        // Load B with a distinct pattern
        send_byte(8'h02);
        for (int i = 0; i < N_ELEMENTS; i++) load_byte(1'b1, i, 8'(i) ^ 8'hA5);
        chk("vl_after_b", 32'(vec_loaded), 32'd3);

        // dot command held until ack, overrun in between
        send_byte(8'h08);
        chk("dot_valid", 32'(cmd_valid), 32'd1);
        chk("dot_enables", 32'(enables), 32'h20);
        repeat (3) @(negedge clk);
        chk("dot_held", 32'({cmd_valid, enables}), 32'h60);
        send_byte(8'h05);
        chk("overrun_err", 32'(rx_error), 32'd1);
        chk("overrun_held", 32'({cmd_valid, enables}), 32'h60);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("dot_cleared", 32'({cmd_valid, enables}), 32'd0);

        // Illegal opcodes
        send_byte(8'h00);
        chk("illegal_00", 32'(rx_error), 32'd1);
        send_byte(8'h09);
        chk("illegal_09", 32'(rx_error), 32'd1);
        chk("illegal_no_cmd", 32'(cmd_valid), 32'd0);

        // Ack in the very first ISSUE cycle -> single-cycle cmd_valid
        send_byte(8'h03);
        chk("read_enables", 32'({cmd_valid, enables}), 32'h41);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("read_one_cycle", 32'({cmd_valid, enables}), 32'd0);

        // Timeout: 5 bytes into B, then silence
        send_byte(8'h02);
        chk("vl_b_cleared", 32'(vec_loaded), 32'd1);
        for (int i = 0; i < 5; i++) load_byte(1'b1, i, 8'h30 + 8'(i));
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (rx_error) begin
                k = c;
                break;
            end
        end
        chk("timeout_cycles", 32'(k), 32'd50);
        chk("timeout_vl", 32'(vec_loaded), 32'd1);
        send_byte(8'h04);
        chk("post_timeout_cmd_err", 32'(rx_error), 32'd1);
        chk("post_timeout_no_cmd", 32'(cmd_valid), 32'd0);

        // Byte coincident with expiry is written, no error
        send_byte(8'h02);
        load_byte(1'b1, 0, 8'h77);
        repeat (48) @(negedge clk);
        load_byte(1'b1, 1, 8'h78);
        chk("coincident_no_err", 32'(rx_error), 32'd0);
        @(negedge clk);
        chk("coincident_no_err_late", 32'(rx_error), 32'd0);

        // Reset after 10 payload bytes, with a byte arriving during reset
        for (int i = 2; i < 10; i++) load_byte(1'b1, i, 8'h90 + 8'(i));
        @(negedge clk);
        reset    = 1'b1;
        rx_data  = 8'h55;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk_reset_outputs("midload_reset");
        @(negedge clk);
        reset = 1'b0;

        // Fresh load of A from address 0
        send_byte(8'h01);
        for (int i = 0; i < N_ELEMENTS; i++) load_byte(1'b0, i, 8'hC0 + 8'(i));
        chk("vl_after_reload", 32'(vec_loaded), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
